// File: rtl/led_chaser_seq.sv
// Running-light sequencer: produces the LED index and decoder enable code
// for the registered one-of-eight active-low LED decoder downstream.
module led_chaser_seq #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [DIV_W-1:0] period,
    input  logic [2:0]       load_idx,
    input  logic             blank,
    output logic [2:0]       switch,
    output logic [2:0]       enable,
    output logic             tick
);

    localparam int unsigned IDX_W = 3;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(7);
    localparam logic [IDX_W-1:0] IDX_MIN = IDX_W'(0);
    localparam logic [2:0] EN_ON  = 3'd4;
    localparam logic [2:0] EN_OFF = 3'd0;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_HOLD   = 2'd2,
        MODE_LOAD   = 2'd3
    } mode_e;

    typedef enum logic {
        BDIR_UP   = 1'b0,
        BDIR_DOWN = 1'b1
    } bdir_e;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_d;
    bdir_e            bdir_q, bdir_d;
    logic [2:0]       enable_d;
    logic             tick_d;
    logic             step_c;
    mode_e            mode_c;

    assign mode_c = mode_e'(mode);

    // State register: prescaler, index, bounce direction and output flops
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            switch <= IDX_MIN;
            bdir_q <= BDIR_UP;
            enable <= EN_OFF;
            tick   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            switch <= idx_d;
            bdir_q <= bdir_d;
            enable <= enable_d;
            tick   <= tick_d;
        end
    end

    // Next-state: prescaler compare, step action per mode, bounce seeding
    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = switch;
        bdir_d   = bdir_q;
        tick_d   = 1'b0;
        step_c   = 1'b0;
        enable_d = blank ? EN_OFF : EN_ON;

        if (mode_c == MODE_LOAD) begin
            idx_d = load_idx;
            cnt_d = '0;
        end else if (run) begin
            // Exact-match compare: a count already past period wraps through max
            if (cnt_q == period) begin
                cnt_d  = '0;
                step_c = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        if (step_c) begin
            tick_d = 1'b1;
            unique case (mode_c)
                MODE_WRAP: begin
                    idx_d = dir ? switch + IDX_W'(1) : switch - IDX_W'(1);
                end
                MODE_BOUNCE: begin
                    if (bdir_q == BDIR_UP) begin
                        // At the top already: turn around instead of wrapping
                        if (switch == IDX_MAX) begin
                            idx_d  = switch - IDX_W'(1);
                            bdir_d = BDIR_DOWN;
                        end else begin
                            idx_d = switch + IDX_W'(1);
                            if (switch == IDX_MAX - IDX_W'(1)) begin
                                bdir_d = BDIR_DOWN;
                            end
                        end
                    end else begin
                        if (switch == IDX_MIN) begin
                            idx_d  = switch + IDX_W'(1);
                            bdir_d = BDIR_UP;
                        end else begin
                            idx_d = switch - IDX_W'(1);
                            if (switch == IDX_MIN + IDX_W'(1)) begin
                                bdir_d = BDIR_UP;
                            end
                        end
                    end
                end
                MODE_HOLD: begin
                    idx_d = switch;
                end
                default: begin
                    idx_d = switch;
                end
            endcase
        end

        // Outside bounce, keep the bounce direction seeded from dir
        if (mode_c != MODE_BOUNCE) begin
            bdir_d = dir ? BDIR_UP : BDIR_DOWN;
        end
    end

endmodule

// File: tb/tb_led_chaser_seq.sv
// Directed vector bench for led_chaser_seq.
module tb_led_chaser_seq;

    localparam int unsigned DIV_W = 4;

    logic             clk;
    logic             rst;
    logic             run;
    logic [1:0]       mode;
    logic             dir;
    logic [DIV_W-1:0] period;
    logic [2:0]       load_idx;
    logic             blank;
    logic [2:0]       switch;
    logic [2:0]       enable;
    logic             tick;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string            tag;
        logic             v_rst;
        logic             v_run;
        logic [1:0]       v_mode;
        logic             v_dir;
        logic [DIV_W-1:0] v_period;
        logic [2:0]       v_ld;
        logic             v_blank;
        logic [2:0]       e_sw;
        logic [2:0]       e_en;
        logic             e_tk;
    } vec_t;

    vec_t vecs[$];

    led_chaser_seq #(.DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .mode     (mode),
        .dir      (dir),
        .period   (period),
        .load_idx (load_idx),
        .blank    (blank),
        .switch   (switch),
        .enable   (enable),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input string tag, input logic r, input logic rn, input logic [1:0] m,
                       input logic d, input int p, input int ld, input logic b,
                       input int esw, input int een, input logic etk);
        vec_t v;
        v.tag = tag; v.v_rst = r; v.v_run = rn; v.v_mode = m; v.v_dir = d;
        v.v_period = DIV_W'(p); v.v_ld = 3'(ld); v.v_blank = b;
        v.e_sw = 3'(esw); v.e_en = 3'(een); v.e_tk = etk;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic rn, input logic [1:0] m, input logic d,
                         input int p, input int ld, input logic b);
        rst = r; run = rn; mode = m; dir = d; period = DIV_W'(p); load_idx = 3'(ld); blank = b;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] esw, input logic [2:0] een,
                         input logic etk);
        n_checks++;
        if (switch !== esw || enable !== een || tick !== etk) begin
            n_errors++;
            $display("FAIL %s: got switch=%0d enable=%0d tick=%0b, expected switch=%0d enable=%0d tick=%0b",
                     name, switch, enable, tick, esw, een, etk);
        end
    endtask

    initial begin
        int bseq [11] = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        int n_edges;
        bit held;

        // Reset then idle
        repeat (3) add("reset", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) add("idle", 1, 0, 0, 1, 0, 0, 0, 0, 4, 0);
        // WRAP up from 6, period 2
        add("wrapup_ld", 1, 0, 3, 1, 0, 6, 0, 6, 4, 0);
        for (int i = 0; i < 9; i++)
            add("wrapup", 1, 1, 0, 1, 2, 0, 0, (6 + (i + 1) / 3) % 8, 4, (i % 3) == 2);
        // WRAP down from 1, period 0
        add("wrapdn_ld", 1, 0, 3, 0, 0, 1, 0, 1, 4, 0);
        for (int i = 0; i < 4; i++)
            add("wrapdn", 1, 1, 0, 0, 0, 0, 0, (8 - i) % 8, 4, 1);
        // BOUNCE seeded up at 5; dir ignored while bouncing
        add("bnc_ld", 1, 0, 3, 1, 0, 5, 0, 5, 4, 0);
        for (int i = 0; i < 11; i++)
            add("bounce", 1, 1, 1, 0, 0, 0, 0, bseq[i], 4, 1);
        // HOLD, period 1: tick continues, index frozen
        for (int i = 0; i < 4; i++)
            add("hold", 1, 1, 2, 1, 1, 0, 0, 2, 4, (i % 2) == 1);
        // run=0 freezes prescaler and index
        repeat (2) add("freeze", 1, 0, 0, 1, 1, 0, 0, 2, 4, 0);
        add("resume0", 1, 1, 0, 1, 1, 0, 0, 2, 4, 0);
        add("resume1", 1, 1, 0, 1, 1, 0, 0, 3, 4, 1);
        // LOAD 5 with run=0, then WRAP period 3
        add("load", 1, 0, 3, 1, 3, 5, 0, 5, 4, 0);
        for (int i = 0; i < 4; i++)
            add("postload", 1, 1, 0, 1, 3, 0, 0, (i == 3) ? 6 : 5, 4, i == 3);
        // blank while stepping
        add("blank0", 1, 1, 0, 1, 0, 0, 1, 7, 0, 1);
        add("blank1", 1, 1, 0, 1, 0, 0, 1, 0, 0, 1);
        add("unblank", 1, 1, 0, 1, 0, 0, 0, 1, 4, 1);

        drive(0, 0, 0, 1, 0, 0, 0);
        foreach (vecs[i]) begin
            drive(vecs[i].v_rst, vecs[i].v_run, vecs[i].v_mode, vecs[i].v_dir,
                  int'(vecs[i].v_period), int'(vecs[i].v_ld), vecs[i].v_blank);
            edge_wait();
            check($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].e_sw, vecs[i].e_en, vecs[i].e_tk);
        end

        // Period lowered below the running count: count wraps through max, no forced step
        drive(1, 1, 0, 1, 3, 0, 0);
        edge_wait();
        check("pwrap_pre0", 3'd1, 3'd4, 1'b0);
        edge_wait();
        check("pwrap_pre1", 3'd1, 3'd4, 1'b0);
        period = DIV_W'(1);
        n_edges = 0;
        held = 1'b1;
        while (n_edges < 40) begin
            edge_wait();
            n_edges++;
            if (tick) break;
            if (switch !== 3'd1) held = 1'b0;
        end
        n_checks++;
        if (n_edges != 16 || !held || switch !== 3'd2) begin
            n_errors++;
            $display("FAIL pwrap: got edges=%0d held=%0b switch=%0d, expected edges=16 held=1 switch=2",
                     n_edges, held, switch);
        end

        // Reset asserted in a step cycle with LOAD selected
        drive(1, 1, 0, 1, 0, 0, 0);
        edge_wait();
        check("prestep", 3'd3, 3'd4, 1'b1);
        drive(0, 1, 3, 1, 0, 5, 0);
        edge_wait();
        check("rst_in_step", 3'd0, 3'd0, 1'b0);
        drive(1, 1, 0, 1, 2, 0, 0);
        edge_wait();
        check("post_rst0", 3'd0, 3'd4, 1'b0);
        edge_wait();
        check("post_rst1", 3'd0, 3'd4, 1'b0);
        edge_wait();
        check("post_rst2", 3'd1, 3'd4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_chaser_seq.md
# led_chaser_seq

Running-light sequencer that generates the 3-bit LED index (`switch`) and the decoder enable code (`enable`) for the registered one-of-eight active-low LED decoder directly downstream. It advances the index at a programmable rate, in one of four modes: wrap, bounce, hold or load. All outputs are registered and change only on the rising edge of `clk`.

## Interface
- `DIV_W`, default 8: prescaler width; the step period is `period`+1 clock cycles.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-low reset; has priority over every other input.
- `run` input 1: 1 = prescaler counts and steps occur; 0 = prescaler and index freeze.
- `mode` input 2: 0 WRAP, 1 BOUNCE, 2 HOLD, 3 LOAD.
- `dir` input 1: 1 = up (+1), 0 = down (−1). Used in WRAP and to seed BOUNCE.
- `period` input DIV_W: terminal count of the prescaler.
- `load_idx` input 3: index value used in LOAD mode.
- `blank` input 1: 1 forces `enable` to 3'd0 (downstream LEDs all off).
- `switch` output 3: current LED index, registered.
- `enable` output 3: 3'd4 = display on; 3'd0 = blank; no other values are driven.
- `tick` output 1: one-cycle pulse, high in the cycle a stepped index first appears on `switch`.

## Operation
- Internal state: `cnt` [DIV_W-1:0] prescaler; `idx` [2:0] (drives `switch`); `bdir` 1-bit bounce direction (UP/DOWN).
- Reset (`rst`=0 at a clock edge): `cnt`=0, `idx`=0, `bdir`=UP, `switch`=0, `enable`=3'd0, `tick`=0.
- `enable` register: loads 3'd0 if `blank`=1, else 3'd4. It is updated every non-reset cycle, independent of `run` and `mode`.
- Prescaler, when `run`=1 and `mode`≠LOAD:
  - if `cnt`==`period`: set `cnt`=0 and generate a step;
  - else `cnt`+1.
  - `period`=0 gives one step per clock.
- `run`=0: `cnt` and `idx` hold, no step, `tick`=0.
- Step action by mode, evaluated with the `mode` value present at the step edge:
  - WRAP: `idx` ±1 mod 8 per `dir` (7→0 up, 0→7 down).
  - BOUNCE, state UP: `idx`+1; if the new `idx`==7, `bdir`←DOWN.
  - BOUNCE, state DOWN: `idx`−1; if the new `idx`==0, `bdir`←UP.
  - BOUNCE guard: if the step starts at 7 with `bdir`=UP, or at 0 with `bdir`=DOWN, flip `bdir` and step the opposite way (no out-of-range move).
  - HOLD: `idx` unchanged. `tick` still pulses, so rate monitoring continues.
- LOAD mode, every cycle regardless of `run`: `idx`←`load_idx`, `cnt`←0, `tick`=0.
- While `mode`≠BOUNCE: `bdir` tracks `dir` every cycle (1→UP), so BOUNCE starts in the direction last selected.
- `period` changes mid-count take effect immediately. If `cnt`>`period`, `cnt` keeps counting, wraps through 2^DIV_W−1 to 0, and then compares normally. No forced step.

## Timing
- Step latency: with `run` held at 1 from edge E0 and `cnt`=0, the step edge is E0+`period`. The new `switch` and `tick`=1 are visible after that edge.
- Steady-state stepping: `tick` high 1 cycle out of every `period`+1; `switch` changes only in `tick` cycles (LOAD excepted).
- LOAD: `switch` equals `load_idx` one cycle after the edge at which `mode`=3 is sampled.
- Leaving LOAD: the prescaler restarts from 0, so the first step comes `period`+1 edges after the last LOAD edge.
- `blank`: `enable` follows it with 1-cycle latency.
- Mid-operation reset: all outputs take their reset values at the first edge with `rst`=0. The first step after release needs a full `period`+1 edges.
- Downstream decoder adds one further register stage. Total `switch`→LED latency is outside this block.

## Test plan
- Reset/idle: hold `rst`=0 for 3 edges, then release with `run`=0, `blank`=0 → `switch`=0, `tick`=0 throughout; `enable`=0 during reset, 3'd4 one edge after release.
- WRAP up, `period`=2, `dir`=1, `run`=1 from `idx`=6 → `switch` sequence 6,7,0,1, each value held 3 cycles; `tick` pulses every third cycle.
- WRAP down, `period`=0 from `idx`=1 → 1,0,7,6,… changing every cycle; `tick` constantly 1.
- BOUNCE, `period`=0, seeded `dir`=1 at `idx`=5 → 6,7,6,5,4,3,2,1,0,1,2; no repeated endpoint values.
- LOAD `load_idx`=5 with `run`=0 → `switch`=5 after 1 edge. Then `mode`=WRAP, `period`=3, `run`=1 → `switch`=6 on the 4th edge after leaving LOAD.
- Simultaneous events:
  - `rst`=0 asserted in a step cycle with `mode`=LOAD and `blank`=0 → `switch`=0, `enable`=0, `tick`=0.
  - `blank`=1 during stepping → `enable`=0 after 1 edge while `switch` keeps advancing.
